interconnect_link_buffer: RTL
=============================

INTERCONNECT_LINK_BUFFER -- requirements
Module: interconnect_link_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, entries per physical plane (power of two, >= 2).
REQ-002 SHALL have port clock  input  1  single clock, positive-edge triggered.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port enable  input  1  active high; low freezes both handshakes.
REQ-005 SHALL have port quiescent  output  1  high when every plane buffer is empty.
REQ-006 SHALL have port input_link_tag_lines  input  TIA_NUM_PHYSICAL_PLANES*TIA_TAG_WIDTH  packed upstream tags, plane p at [TIA_TAG_WIDTH*p +: TIA_TAG_WIDTH].
REQ-007 SHALL have port input_link_data_lines  input  TIA_NUM_PHYSICAL_PLANES*TIA_WORD_WIDTH  packed upstream data, plane p at [TIA_WORD_WIDTH*p +: TIA_WORD_WIDTH].
REQ-008 SHALL have port input_link_reqs  input  TIA_NUM_PHYSICAL_PLANES  upstream packet valid per plane.
REQ-009 SHALL have port input_link_acks  output  TIA_NUM_PHYSICAL_PLANES  buffer can accept, per plane.
REQ-010 SHALL have port output_link_tag_lines  output  TIA_NUM_PHYSICAL_PLANES*TIA_TAG_WIDTH  head-entry tags, same packing.
REQ-011 SHALL have port output_link_data_lines  output  TIA_NUM_PHYSICAL_PLANES*TIA_WORD_WIDTH  head-entry data, same packing.
REQ-012 SHALL have port output_link_reqs  output  TIA_NUM_PHYSICAL_PLANES  head entry valid, per plane.
REQ-013 SHALL have port output_link_acks  input  TIA_NUM_PHYSICAL_PLANES  downstream processing element accepts, per plane.

Function
REQ-014 SHALL insert between a processing element output link and the neighbouring element input link; planes fully independent.
REQ-015 SHALL transfer on a plane in a cycle only when that plane's req and ack are both high at the clock edge, on each side independently.
REQ-016 SHALL drive input_link_acks[p] = enable AND (count[p] != DEPTH), from registered state only; no combinational path from output_link_acks.
REQ-017 SHALL drive output_link_reqs[p] = enable AND (count[p] != 0), from registered state only; no combinational path from input_link_reqs.
REQ-018 SHALL present the oldest entry on output tag/data lines; lines SHALL be zero when the plane is empty.
REQ-019 SHALL have minimum latency of one cycle: packet accepted at edge N is offered at output from edge N onward (req visible cycle N+1); no bypass.
REQ-020 SHALL preserve FIFO order per plane; no loss, duplication, or reordering.
REQ-021 SHALL, on simultaneous push and pop on a non-full, non-empty plane, keep count unchanged and advance both pointers.
REQ-022 SHALL, when full, refuse pushes (ack low) even if a pop occurs that same cycle; the slot frees the next cycle.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; count width clog2(DEPTH+1).
REQ-024 SHALL, with enable low, hold all contents and pointers and perform no transfers.
REQ-025 SHALL drive quiescent = AND over planes of (count[p] == 0), independent of enable.

Reset
REQ-026 SHALL, while reset low, asynchronously clear all pointers and counts, discarding in-flight entries, including mid-transfer.
REQ-027 SHALL, while reset is low, hold output_link_reqs = 0, output tag/data lines = 0, and quiescent = 1; input_link_acks SHALL equal enable replicated.
REQ-028 SHALL not require storage array contents to be reset.

Structure
REQ-029 SHALL take TIA_NUM_PHYSICAL_PLANES, TIA_TAG_WIDTH, and TIA_WORD_WIDTH from the shared processing_element package; a link_entry_t typedef {tag, data} SHALL be added there.
REQ-030 SHALL instantiate one sub-module link_plane_fifo per plane via generate; the top only packs and unpacks vectors and ANDs the quiescent flags.

Verification
REQ-031 SHALL verify reset then single push: plane 0 req=1, tag=1, data=0x0000_00AB with out ack=0 -> next cycle out req[0]=1, data 0xAB, quiescent=0, other planes idle.
REQ-032 SHALL verify fill: DEPTH=2, 3 back-to-back pushes with out ack=0 -> first two accepted, in ack low from cycle 2, third held at upstream; pop -> ack high the following cycle.
REQ-033 SHALL verify streaming: continuous push 0..99 with out ack=1 -> output sequence 0..99 in order, throughput 1 per cycle after first.
REQ-034 SHALL verify full plus simultaneous pop and push: push refused that cycle, accepted next cycle; order intact.
REQ-035 SHALL verify enable low with 1 entry buffered: out req=0, in ack=0, entry retained; enable high -> entry delivered.
REQ-036 SHALL verify asynchronous reset asserted mid-stream between edges: out reqs drop immediately, quiescent=1; after release, fresh traffic only.

Source files
------------

// File: rtl/processing_element_pkg.sv
// -----------------------------------------------------------------------------
// processing_element_pkg
// Shared constants and types for the processing element link fabric.
//   TIA_NUM_PHYSICAL_PLANES : independent physical link planes per link
//   TIA_TAG_WIDTH           : width of the tag carried with each packet
//   TIA_WORD_WIDTH          : width of the data word carried with each packet
//   link_entry_t            : one buffered packet {tag, data}
// -----------------------------------------------------------------------------
package processing_element_pkg;

    localparam int TIA_NUM_PHYSICAL_PLANES = 2;
    localparam int TIA_TAG_WIDTH           = 4;
    localparam int TIA_WORD_WIDTH          = 32;

    typedef struct packed {
        logic [TIA_TAG_WIDTH-1:0]  tag;
        logic [TIA_WORD_WIDTH-1:0] data;
    } link_entry_t;

endpackage

// File: rtl/link_plane_fifo.sv
// -----------------------------------------------------------------------------
// link_plane_fifo
// Single-plane req/ack FIFO of DEPTH entries (power of two, >= 2).
// Both handshake outputs come from registered state only, so there is no
// combinational path from either side's req/ack to the other side.
//   clock     : positive-edge clock
//   reset     : asynchronous active-low reset (clears pointers and count)
//   enable    : low freezes both handshakes and all state
//   in_req    : upstream packet valid
//   in_entry  : upstream packet {tag, data}
//   in_ack    : buffer can accept (enable and not full)
//   out_req   : head entry valid (enable and not empty)
//   out_entry : oldest entry, zero when empty
//   out_ack   : downstream accepts the head entry
//   empty     : no entries held (independent of enable)
// -----------------------------------------------------------------------------
module link_plane_fifo
    import processing_element_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        in_req,
    input  link_entry_t in_entry,
    output logic        in_ack,
    output logic        out_req,
    output link_entry_t out_entry,
    input  logic        out_ack,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    link_entry_t      mem [DEPTH];

    logic push;
    logic pop;

    // A full buffer refuses a push even when it is popped in the same cycle;
    // the freed slot shows up in in_ack on the following cycle.
    assign in_ack    = enable && (count != FULL_COUNT);
    assign out_req   = enable && (count != '0);
    assign empty     = (count == '0);
    assign out_entry = empty ? '0 : mem[rd_ptr];

    assign push = in_req  && in_ack;
    assign pop  = out_ack && out_req;

    // Pointers are PTR_W bits wide, so incrementing wraps modulo DEPTH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its inputs from before the edge, regardless of
            // statement order or of other always blocks.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately left out of reset; a cleared
    // count already marks every slot invalid, and out_entry is masked to zero
    // while empty, so stale contents are never observable.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

endmodule

// File: rtl/interconnect_link_buffer.sv
// -----------------------------------------------------------------------------
// interconnect_link_buffer
// Elastic buffer inserted between a processing element output link and the
// neighbouring element input link. Each physical plane is an independent
// link_plane_fifo; this level only unpacks/packs the plane vectors and
// combines the per-plane empty flags.
//   clock                  : positive-edge clock
//   reset                  : asynchronous active-low reset
//   enable                 : low freezes both handshakes on every plane
//   quiescent              : every plane buffer empty (independent of enable)
//   input_link_tag_lines   : packed upstream tags, plane p at [TW*p +: TW]
//   input_link_data_lines  : packed upstream data, plane p at [WW*p +: WW]
//   input_link_reqs        : upstream packet valid per plane
//   input_link_acks        : buffer can accept, per plane
//   output_link_tag_lines  : head-entry tags, same packing (zero when empty)
//   output_link_data_lines : head-entry data, same packing (zero when empty)
//   output_link_reqs       : head entry valid, per plane
//   output_link_acks       : downstream accepts, per plane
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module interconnect_link_buffer
    import processing_element_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic                                              enable,
    output logic                                              quiescent,
    input  logic [TIA_NUM_PHYSICAL_PLANES*TIA_TAG_WIDTH-1:0]  input_link_tag_lines,
    input  logic [TIA_NUM_PHYSICAL_PLANES*TIA_WORD_WIDTH-1:0] input_link_data_lines,
    input  logic [TIA_NUM_PHYSICAL_PLANES-1:0]                input_link_reqs,
    output logic [TIA_NUM_PHYSICAL_PLANES-1:0]                input_link_acks,
    output logic [TIA_NUM_PHYSICAL_PLANES*TIA_TAG_WIDTH-1:0]  output_link_tag_lines,
    output logic [TIA_NUM_PHYSICAL_PLANES*TIA_WORD_WIDTH-1:0] output_link_data_lines,
    output logic [TIA_NUM_PHYSICAL_PLANES-1:0]                output_link_reqs,
    input  logic [TIA_NUM_PHYSICAL_PLANES-1:0]                output_link_acks
);

    logic [TIA_NUM_PHYSICAL_PLANES-1:0] plane_empty;

    for (genvar p = 0; p < TIA_NUM_PHYSICAL_PLANES; p++) begin : g_plane
        link_entry_t in_entry;
        link_entry_t out_entry;

        assign in_entry.tag  = input_link_tag_lines [TIA_TAG_WIDTH*p  +: TIA_TAG_WIDTH];
        assign in_entry.data = input_link_data_lines[TIA_WORD_WIDTH*p +: TIA_WORD_WIDTH];

        link_plane_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .enable    (enable),
            .in_req    (input_link_reqs[p]),
            .in_entry  (in_entry),
            .in_ack    (input_link_acks[p]),
            .out_req   (output_link_reqs[p]),
            .out_entry (out_entry),
            .out_ack   (output_link_acks[p]),
            .empty     (plane_empty[p])
        );

        assign output_link_tag_lines [TIA_TAG_WIDTH*p  +: TIA_TAG_WIDTH]  = out_entry.tag;
        assign output_link_data_lines[TIA_WORD_WIDTH*p +: TIA_WORD_WIDTH] = out_entry.data;
    end

    assign quiescent = &plane_empty;

endmodule
